// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate / load-data extension unit for the MIPS datapath.
// Extends an IN_W-bit field to OUT_W bits in one of five modes. A valid/ready handshake
// with a one-entry skid buffer lets in_ready come straight from a flop instead of
// depending combinationally on out_ready.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt
);

   // Widths of the fill fields that pad the input up to the output width.
   localparam int PAD_W      = OUT_W - IN_W;
   localparam int BYTE_PAD_W = OUT_W - 8;

   // The counter stops at its all-ones value.
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Legal extension modes. The codes 101..111 are illegal and produce an error result.
   typedef enum logic [2:0] {
      MODE_ZEXT      = 3'b000,
      MODE_SEXT      = 3'b001,
      MODE_UPPER     = 3'b010,
      MODE_SEXT_BYTE = 3'b011,
      MODE_ZEXT_BYTE = 3'b100
   } mode_e;

   // Main output register (M).
   logic             m_valid_q, m_valid_d;
   logic [OUT_W-1:0] m_data_q,  m_data_d;
   logic             m_err_q,   m_err_d;

   // Skid register (S). It holds a result only while M is stalled.
   logic             s_valid_q, s_valid_d;
   logic [OUT_W-1:0] s_data_q,  s_data_d;
   logic             s_err_q,   s_err_d;

   // Saturating count of accepted illegal-mode transfers.
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Extension result for the current input and the two handshake events.
   logic [OUT_W-1:0] ext_data;
   logic             ext_err;
   logic             acc;
   logic             pop;

   // Ready depends only on the skid flop. It is also forced low while reset is held.
   assign in_ready  = ~s_valid_q & ~reset;
   assign acc       = in_valid & in_ready;
   assign pop       = m_valid_q & out_ready;

   assign out_valid = m_valid_q;
   assign out_data  = m_data_q;
   assign out_err   = m_err_q;
   assign err_cnt   = err_cnt_q;

   // Combinational extension of the incoming field according to the selected mode.
   always_comb begin
      ext_data = '0;
      ext_err  = 1'b0;
      case (in_mode)
         MODE_ZEXT:      ext_data = {{PAD_W{1'b0}}, in_data};
         MODE_SEXT:      ext_data = {{PAD_W{in_data[IN_W-1]}}, in_data};
         MODE_UPPER:     ext_data = {in_data, {PAD_W{1'b0}}};
         MODE_SEXT_BYTE: ext_data = {{BYTE_PAD_W{in_data[7]}}, in_data[7:0]};
         MODE_ZEXT_BYTE: ext_data = {{BYTE_PAD_W{1'b0}}, in_data[7:0]};
         default: begin
            ext_data = '0;
            ext_err  = 1'b1;
         end
      endcase
   end

   // Next-state logic for the two-entry FIFO (M then S) and the illegal-mode counter.
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_err_d   = m_err_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_err_d   = s_err_q;
      err_cnt_d = err_cnt_q;

      if (pop && s_valid_q) begin
         // Consumer takes M and the skid entry moves up. in_ready is low, so there is no accept.
         m_valid_d = 1'b1;
         m_data_d  = s_data_q;
         m_err_d   = s_err_q;
         s_valid_d = 1'b0;
      end else if (!m_valid_q || pop) begin
         // M is free this edge. Load a new result or go empty. Data is kept when empty.
         if (acc) begin
            m_valid_d = 1'b1;
            m_data_d  = ext_data;
            m_err_d   = ext_err;
         end else if (pop) begin
            m_valid_d = 1'b0;
         end
      end else if (acc) begin
         // M is stalled, so the new result goes into the skid register.
         s_valid_d = 1'b1;
         s_data_d  = ext_data;
         s_err_d   = ext_err;
      end

      if (acc && ext_err && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // State registers. Synchronous reset drops every held result and clears the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_err_q   <= 1'b0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_err_q   <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_err_q   <= m_err_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_err_q   <= s_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed checks of imm_extend_pipe. The main instance uses the
// default widths. A CNT_W=2 twin shares its inputs, and two extra width configurations
// are also instantiated.
module tb_imm_extend_pipe;

   logic clk = 1'b0;
   logic reset;

   // Inputs shared by the main instance and its CNT_W=2 twin.
   logic        in_valid;
   logic [15:0] in_data;
   logic [2:0]  in_mode;
   logic        out_ready;

   // Main instance outputs.
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_err;
   logic [7:0]  err_cnt;

   // CNT_W=2 twin outputs.
   logic        sm_in_ready;
   logic        sm_out_valid;
   logic [31:0] sm_out_data;
   logic        sm_out_err;
   logic [1:0]  sm_err_cnt;

   // IN_W=8, OUT_W=16 instance signals.
   logic        b_in_valid;
   logic        b_in_ready;
   logic [7:0]  b_in_data;
   logic [2:0]  b_in_mode;
   logic        b_out_valid;
   logic [15:0] b_out_data;
   logic        b_out_err;
   logic [7:0]  b_err_cnt;

   // IN_W=12, OUT_W=32 instance signals.
   logic        t_in_valid;
   logic        t_in_ready;
   logic [11:0] t_in_data;
   logic [2:0]  t_in_mode;
   logic        t_out_valid;
   logic [31:0] t_out_data;
   logic        t_out_err;
   logic [7:0]  t_err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_prev;
   logic [15:0] rnd_data;
   logic [2:0]  rnd_mode;

   logic [31:0] vec_exp  [5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFF80, 32'h00000080};
   logic [15:0] vec_data [5] = '{16'h8001, 16'h8001, 16'h1234, 16'h0080, 16'h0080};
   logic [2:0]  vec_mode [5] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b100};

   always #5 clk = ~clk;

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt));

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sm_in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(sm_out_valid), .out_ready(out_ready),
      .out_data(sm_out_data), .out_err(sm_out_err), .err_cnt(sm_err_cnt));

   imm_extend_pipe #(.IN_W(8), .OUT_W(16), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(1'b1),
      .out_data(b_out_data), .out_err(b_out_err), .err_cnt(b_err_cnt));

   imm_extend_pipe #(.IN_W(12), .OUT_W(32), .CNT_W(8)) dut_t (
      .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready),
      .in_data(t_in_data), .in_mode(t_in_mode), .out_valid(t_out_valid), .out_ready(1'b1),
      .out_data(t_out_data), .out_err(t_out_err), .err_cnt(t_err_cnt));

   // Reference extension for the 16 -> 32 configuration.
   function automatic logic [31:0] refExt(input logic [15:0] d, input logic [2:0] m);
      case (m)
         3'b000:  return {16'h0000, d};
         3'b001:  return {{16{d[15]}}, d};
         3'b010:  return {d, 16'h0000};
         3'b011:  return {{24{d[7]}}, d[7:0]};
         3'b100:  return {24'h000000, d[7:0]};
         default: return 32'h0;
      endcase
   endfunction

   // Drive the shared producer inputs.
   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [2:0] m);
      in_valid = v;
      in_data  = d;
      in_mode  = m;
   endtask

   // One counted comparison.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset      = 1'b1;
      out_ready  = 1'b0;
      applyStimulus(1'b0, 16'h0, 3'b000);
      b_in_valid = 1'b0; b_in_data = 8'h0;  b_in_mode = 3'b000;
      t_in_valid = 1'b0; t_in_data = 12'h0; t_in_mode = 3'b000;

      // Reset state
      $display("[TB] reset");
      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready_held", {31'b0, in_ready}, 32'h0);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("rst_out_data", out_data, 32'h0);
      checkOutput("rst_out_err", {31'b0, out_err}, 32'h0);
      checkOutput("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
      reset = 1'b0;
      #1;
      checkOutput("rst_in_ready_release", {31'b0, in_ready}, 32'h1);

      // Test 1: every mode, one result per cycle
      $display("[TB] modes");
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checkOutput("mode_valid", {31'b0, out_valid}, 32'h1);
            checkOutput("mode_data", out_data, vec_exp[i-1]);
            checkOutput("mode_err", {31'b0, out_err}, 32'h0);
         end
         applyStimulus(1'b1, vec_data[i], vec_mode[i]);
      end
      @(negedge clk);
      checkOutput("mode_data_last", out_data, vec_exp[4]);
      applyStimulus(1'b0, 16'h0, 3'b000);
      @(negedge clk);
      checkOutput("mode_drained_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("mode_drained_hold", out_data, 32'h00000080);

      // Test 2: backpressure with A, B, C
      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h0011, 3'b000);
      @(negedge clk);
      checkOutput("bp_ready_after_A", {31'b0, in_ready}, 32'h1);
      applyStimulus(1'b1, 16'hFFFE, 3'b001);
      @(negedge clk);
      checkOutput("bp_ready_after_B", {31'b0, in_ready}, 32'h0);
      checkOutput("bp_data_A", out_data, 32'h00000011);
      applyStimulus(1'b1, 16'h00C3, 3'b011);
      @(negedge clk);
      checkOutput("bp_ready_stall", {31'b0, in_ready}, 32'h0);
      checkOutput("bp_data_A_stable", out_data, 32'h00000011);
      checkOutput("bp_valid_stable", {31'b0, out_valid}, 32'h1);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_data_B", out_data, 32'hFFFFFFFE);
      checkOutput("bp_ready_reopen", {31'b0, in_ready}, 32'h1);
      @(negedge clk);
      checkOutput("bp_data_C", out_data, 32'hFFFFFFC3);
      checkOutput("bp_valid_C", {31'b0, out_valid}, 32'h1);
      applyStimulus(1'b0, 16'h0, 3'b000);
      @(negedge clk);
      checkOutput("bp_empty", {31'b0, out_valid}, 32'h0);

      // Test 3: 100 cycles of streaming with random legal modes
      $display("[TB] streaming");
      exp_prev = 32'h0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checkOutput("stream_valid", {31'b0, out_valid}, 32'h1);
            checkOutput("stream_data", out_data, exp_prev);
            checkOutput("stream_ready", {31'b0, in_ready}, 32'h1);
         end
         rnd_data = 16'($urandom);
         rnd_mode = 3'($urandom_range(0, 4));
         applyStimulus(1'b1, rnd_data, rnd_mode);
         exp_prev = refExt(rnd_data, rnd_mode);
      end
      @(negedge clk);
      checkOutput("stream_data_last", out_data, exp_prev);
      checkOutput("stream_err_cnt", {24'b0, err_cnt}, 32'h0);
      applyStimulus(1'b0, 16'h0, 3'b000);

      // Test 4: illegal modes and counter saturation
      $display("[TB] illegal modes");
      @(negedge clk);
      applyStimulus(1'b1, 16'hFFFF, 3'b111);
      @(negedge clk);
      checkOutput("ill_data", out_data, 32'h0);
      checkOutput("ill_err", {31'b0, out_err}, 32'h1);
      checkOutput("ill_cnt_1", {24'b0, err_cnt}, 32'h1);
      checkOutput("ill_small_cnt_1", {30'b0, sm_err_cnt}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 16'h1234 + 16'(i), 3'(5 + (i % 3)));
         @(negedge clk);
         checkOutput("ill_loop_err", {31'b0, out_err}, 32'h1);
         checkOutput("ill_loop_data", out_data, 32'h0);
      end
      applyStimulus(1'b0, 16'h0, 3'b000);
      checkOutput("ill_cnt_6", {24'b0, err_cnt}, 32'h6);
      checkOutput("ill_small_sat", {30'b0, sm_err_cnt}, 32'h3);

      // Test 5: reset while M and S are both full
      $display("[TB] reset mid-operation");
      @(negedge clk);
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h0000, 3'b110);
      @(negedge clk);
      applyStimulus(1'b1, 16'h5555, 3'b000);
      @(negedge clk);
      checkOutput("mid_full_ready", {31'b0, in_ready}, 32'h0);
      checkOutput("mid_full_err", {31'b0, out_err}, 32'h1);
      checkOutput("mid_cnt_7", {24'b0, err_cnt}, 32'h7);
      applyStimulus(1'b0, 16'h0, 3'b000);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid_ready_in_reset", {31'b0, in_ready}, 32'h0);
      reset = 1'b0;
      #1;
      checkOutput("mid_out_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("mid_out_data", out_data, 32'h0);
      checkOutput("mid_out_err", {31'b0, out_err}, 32'h0);
      checkOutput("mid_err_cnt", {24'b0, err_cnt}, 32'h0);
      checkOutput("mid_small_cnt", {30'b0, sm_err_cnt}, 32'h0);
      checkOutput("mid_in_ready", {31'b0, in_ready}, 32'h1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("mid_no_emit", {31'b0, out_valid}, 32'h0);
      end

      // Test 6: other width configurations
      $display("[TB] parameter sweep");
      b_in_valid = 1'b1; b_in_data = 8'h80;   b_in_mode = 3'b001;
      t_in_valid = 1'b1; t_in_data = 12'hABC; t_in_mode = 3'b010;
      @(negedge clk);
      checkOutput("w8_sext", {16'b0, b_out_data}, 32'h0000FF80);
      checkOutput("w12_upper", t_out_data, 32'hABC00000);
      b_in_data = 8'hAB;  b_in_mode = 3'b010;
      t_in_data = 12'h800; t_in_mode = 3'b001;
      @(negedge clk);
      checkOutput("w8_upper", {16'b0, b_out_data}, 32'h0000AB00);
      checkOutput("w12_sext", t_out_data, 32'hFFFFF800);
      checkOutput("w12_valid", {31'b0, t_out_valid}, 32'h1);
      b_in_valid = 1'b0;
      t_in_valid = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
